// File: rtl/serial_parity_pkg.sv
// Shared types and helpers for the serial parity transmitter.
// Holds the FSM state encoding, parity-mode constants and counter sizing.
package serial_parity_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2
  } state_t;

  localparam int EVEN = 0;
  localparam int ODD  = 1;

  function automatic int cnt_w(input int data_w);
    return $clog2(data_w);
  endfunction

endpackage

// File: rtl/serial_parity_tx.sv
// Parallel-to-serial transmitter: shifts a word out LSB first and appends one
// parity bit, streaming back-to-back frames when the producer keeps in_valid high.
module serial_parity_tx
  import serial_parity_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter bit ODD_PARITY = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              sout,
  output logic              sout_valid,
  output logic              sout_last,
  output logic              busy
);

  localparam int              CW       = cnt_w(DATA_W);
  localparam logic [CW-1:0]   CNT_LAST = CW'(DATA_W - 1);
  localparam logic            PAR_INIT = (int'(ODD_PARITY) == ODD) ? 1'b1 : 1'b0;

  state_t              state_q, state_d;
  logic [DATA_W-1:0]   shreg_q, shreg_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic                acc_q, acc_d;
  logic                sout_q, sout_d;
  logic                sout_valid_q, sout_valid_d;
  logic                sout_last_q, sout_last_d;
  logic                busy_q, busy_d;
  logic                accept;

  // A new word may be taken while idle or during the parity bit, which keeps frames gapless.
  assign in_ready = (state_q != DATA);
  assign accept   = in_valid && in_ready;

  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;

    if (accept) begin
      shreg_d = in_data;
      cnt_d   = '0;
      acc_d   = PAR_INIT;
      state_d = DATA;
    end else begin
      case (state_q)
        DATA: begin
          acc_d   = acc_q ^ shreg_q[0];
          shreg_d = shreg_q >> 1;
          if (cnt_q == CNT_LAST) begin
            state_d = PARITY;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        PARITY:  state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end

    // Outputs are registered, so they are derived from the next-state values.
    sout_d       = 1'b0;
    sout_valid_d = 1'b0;
    sout_last_d  = 1'b0;
    case (state_d)
      DATA: begin
        sout_d       = shreg_d[0];
        sout_valid_d = 1'b1;
      end
      PARITY: begin
        sout_d       = acc_d;
        sout_valid_d = 1'b1;
        sout_last_d  = 1'b1;
      end
      default: ;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      shreg_q      <= '0;
      cnt_q        <= '0;
      acc_q        <= 1'b0;
      sout_q       <= 1'b0;
      sout_valid_q <= 1'b0;
      sout_last_q  <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      shreg_q      <= shreg_d;
      cnt_q        <= cnt_d;
      acc_q        <= acc_d;
      sout_q       <= sout_d;
      sout_valid_q <= sout_valid_d;
      sout_last_q  <= sout_last_d;
      busy_q       <= busy_d;
    end
  end

  assign sout       = sout_q;
  assign sout_valid = sout_valid_q;
  assign sout_last  = sout_last_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_serial_parity_tx.sv
// Bench for serial_parity_tx: an even and an odd instance share one stimulus
// stream and are compared every cycle against a frame-queue model.
module tb_serial_parity_tx;

  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic [DW-1:0] in_data = '0;

  logic in_ready_e, sout_e, sout_valid_e, sout_last_e, busy_e;
  logic in_ready_o, sout_o, sout_valid_o, sout_last_o, busy_o;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  serial_parity_tx #(.DATA_W(DW), .ODD_PARITY(1'b0)) dut_even (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready_e), .sout(sout_e), .sout_valid(sout_valid_e),
    .sout_last(sout_last_e), .busy(busy_e)
  );

  serial_parity_tx #(.DATA_W(DW), .ODD_PARITY(1'b1)) dut_odd (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready_o), .sout(sout_o), .sout_valid(sout_valid_o),
    .sout_last(sout_last_o), .busy(busy_o)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Model: each accepted word becomes DW data bits (LSB first) plus an
  // even-parity bit; the odd instance's parity bit is its complement.
  bit q_bit[$];
  bit q_last[$];
  bit cur_v = 1'b0, cur_b = 1'b0, cur_l = 1'b0;

  initial forever begin
    @(posedge clk);
    if (!rst_n) begin
      q_bit.delete();
      q_last.delete();
      cur_v = 1'b0; cur_b = 1'b0; cur_l = 1'b0;
    end else begin
      if (in_valid && (!cur_v || cur_l)) begin
        for (int i = 0; i < DW; i++) begin
          q_bit.push_back(in_data[i]);
          q_last.push_back(1'b0);
        end
        q_bit.push_back(^in_data);
        q_last.push_back(1'b1);
      end
      if (q_bit.size() > 0) begin
        cur_b = q_bit.pop_front();
        cur_l = q_last.pop_front();
        cur_v = 1'b1;
      end else begin
        cur_v = 1'b0; cur_b = 1'b0; cur_l = 1'b0;
      end
    end
  end

  // Per-cycle compare plus capture of whole frames for the literal checks.
  logic [DW:0] cap_e, cap_o;
  logic [DW:0] frames_e[$];
  logic [DW:0] frames_o[$];
  int idx = 0;
  int run = 0;
  int last_run = 0;

  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      check("in_ready", {31'd0, in_ready_e}, {31'd0, !cur_v || cur_l});
      check("even_valid", {31'd0, sout_valid_e}, {31'd0, cur_v});
      check("even_last", {31'd0, sout_last_e}, {31'd0, cur_l});
      check("even_sout", {31'd0, sout_e}, {31'd0, cur_b});
      check("even_busy", {31'd0, busy_e}, {31'd0, cur_v});
      check("odd_valid", {31'd0, sout_valid_o}, {31'd0, cur_v});
      check("odd_last", {31'd0, sout_last_o}, {31'd0, cur_l});
      check("odd_sout", {31'd0, sout_o}, {31'd0, cur_b ^ cur_l});
      check("odd_ready", {31'd0, in_ready_o}, {31'd0, !cur_v || cur_l});
    end
    if (!rst_n) begin
      idx = 0;
    end else if (sout_valid_e && idx <= DW) begin
      cap_e[idx] = sout_e;
      cap_o[idx] = sout_o;
      idx++;
      if (sout_last_e) begin
        frames_e.push_back(cap_e);
        frames_o.push_back(cap_o);
        idx = 0;
      end
    end
    if (sout_valid_e === 1'b1) begin
      run++;
    end else begin
      if (run > 0) last_run = run;
      run = 0;
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Offers a word and returns one step after the edge that takes it.
  task automatic send(input logic [DW-1:0] d);
    int n;
    in_valid = 1'b1;
    in_data  = d;
    n = 0;
    @(negedge clk);
    while (in_ready_e !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (n >= 40) check("send_timeout", 32'd1, 32'd0);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic expect_frame(input string name, input logic [DW:0] e, input logic [DW:0] o);
    if (frames_e.size() == 0 || frames_o.size() == 0) begin
      check({name, "_missing"}, 32'd0, 32'd1);
    end else begin
      check({name, "_even"}, 32'(frames_e.pop_front()), 32'(e));
      check({name, "_odd"}, 32'(frames_o.pop_front()), 32'(o));
    end
  endtask

  initial begin
    // Reset held for two edges with a word on offer: nothing may be accepted.
    rst_n    = 1'b0;
    in_valid = 1'b1;
    in_data  = 8'hB4;
    @(posedge clk);
    #1 chk_en = 1'b1;
    @(posedge clk);
    #1 rst_n = 1'b1;

    send(8'hB4);
    idle(12);
    expect_frame("b4", 9'h0B4, 9'h1B4);

    send(8'h07);
    idle(12);
    expect_frame("h07", 9'h107, 9'h007);

    // Back-to-back words: the second is taken on the first frame's parity cycle.
    send(8'hFF);
    send(8'h01);
    idle(12);
    expect_frame("ff", 9'h0FF, 9'h1FF);
    expect_frame("h01", 9'h101, 9'h001);
    check("b2b_run", 32'(last_run), 32'd18);

    // A different word on offer during DATA must be ignored.
    send(8'h5A);
    in_valid = 1'b1;
    in_data  = 8'h33;
    idle(3);
    in_data  = 8'hA5;
    idle(1);
    send(8'hA5);
    idle(12);
    expect_frame("h5a", 9'h05A, 9'h15A);
    expect_frame("ha5", 9'h0A5, 9'h1A5);

    // Reset during bit 4 of a frame drops it with no parity bit.
    send(8'hB4);
    idle(4);
    rst_n = 1'b0;
    idle(1);
    rst_n = 1'b1;
    idle(3);
    check("abort_no_frame", 32'(frames_e.size()), 32'd0);

    send(8'h3C);
    idle(12);
    expect_frame("h3c", 9'h03C, 9'h13C);
    check("tail_empty", 32'(frames_e.size() + frames_o.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, expected finish before 100000");
    $fatal(1);
  end

endmodule
